gpsreceiver2_sampler: RTL

Upstream capture stage of the GPS-SDR receive path. It takes the 2-bit front-end samples (sign, magnitude) on rxb0_clk and packs 16 samples per 32-bit word. It writes each word to the sample buffer and emits a one-cycle strobe that advances the buffer address counter. A start/arm/capture/done state machine, optionally triggered by an external edge, bounds each capture to a programmed number of words and reports completion to control.

---
 rtl/gpsreceiver2_pkg.sv | 23 ++
 rtl/gpsreceiver2_packer.sv | 36 +++
 rtl/gpsreceiver2_sampler.sv | 99 +++++++++
 3 files changed

// File: rtl/gpsreceiver2_pkg.sv
// Shared constants and state encoding for the GPS-SDR sample capture stage.
package gpsreceiver2_pkg;

    localparam int SPW  = 16;
    localparam int AW   = 11;
    localparam int DW   = 2 * SPW;
    localparam int IDXW = $clog2(SPW);
    localparam int CW   = AW + 1;

    // Within each 2-bit sample slot: sign in the upper bit, magnitude in the lower.
    localparam logic SIGN_OFS = 1'b1;
    localparam logic MAG_OFS  = 1'b0;

    localparam logic [CW-1:0] MAX_WORDS = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_DONE
    } state_e;

endpackage

// File: rtl/gpsreceiver2_packer.sv
// Packs one {sign, mag} sample per enabled cycle into a 32-bit word, first sample in bits [1:0].
module gpsreceiver2_packer
    import gpsreceiver2_pkg::*;
(
    input  logic          rxb0_clk,
    input  logic          r_reset,
    input  logic          clear,
    input  logic          en,
    input  logic          sign,
    input  logic          mag,
    output logic [DW-1:0] word,
    output logic          word_valid
);

    logic [DW-1:0]   shreg;
    logic [IDXW-1:0] idx;

    // word already includes the sample arriving this cycle, so it is complete when idx is the last slot.
    always_comb begin
        word                  = shreg;
        word[{idx, SIGN_OFS}] = sign;
        word[{idx, MAG_OFS}]  = mag;
        word_valid            = en && (idx == IDXW'(SPW - 1));
    end

    always_ff @(posedge rxb0_clk) begin
        if (r_reset || clear) begin
            shreg <= '0;
            idx   <= '0;
        end else if (en) begin
            shreg <= word;
            idx   <= idx + IDXW'(1);
        end
    end

endmodule

// File: rtl/gpsreceiver2_sampler.sv
// Capture control: start/arm/capture/done FSM, word counting and buffer write strobes.
module gpsreceiver2_sampler
    import gpsreceiver2_pkg::*;
(
    input  logic          rxb0_clk,
    input  logic          r_reset,
    input  logic          fe_sign,
    input  logic          fe_mag,
    input  logic          ctl_start,
    input  logic          ctl_trig_en,
    input  logic [AW-1:0] ctl_len,
    input  logic          ext_trig,
    output logic          addr_clear,
    output logic          rxb0_we,
    output logic [DW-1:0] rxb0_dat,
    output logic          busy,
    output logic          done,
    output logic          start_ignored
);

    state_e          state, state_next;
    logic [AW-1:0]   len_q;
    logic [CW-1:0]   word_cnt;
    logic [CW-1:0]   len_eff;
    logic            trig_prev;
    logic            trig_edge;
    logic            start_accept;
    logic            pack_en;
    logic [DW-1:0]   pack_word;
    logic            pack_valid;

    gpsreceiver2_packer u_packer (
        .rxb0_clk   (rxb0_clk),
        .r_reset    (r_reset),
        .clear      (start_accept),
        .en         (pack_en),
        .sign       (fe_sign),
        .mag        (fe_mag),
        .word       (pack_word),
        .word_valid (pack_valid)
    );

    always_comb begin
        state_next   = state;
        start_accept = 1'b0;
        pack_en      = 1'b0;
        trig_edge    = ext_trig && !trig_prev;
        len_eff      = (len_q == '0) ? MAX_WORDS : {1'b0, len_q};
        case (state)
            ST_IDLE, ST_DONE: begin
                if (ctl_start) begin
                    start_accept = 1'b1;
                    state_next   = ctl_trig_en ? ST_ARMED : ST_CAPTURE;
                end
            end
            ST_ARMED: begin
                if (trig_edge) state_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                pack_en = 1'b1;
                // Leave on the edge that launches the final write; later samples are dropped.
                if (pack_valid && ((word_cnt + CW'(1)) == len_eff)) state_next = ST_DONE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_ARMED) || (state == ST_CAPTURE);

    always_ff @(posedge rxb0_clk) begin
        if (r_reset) begin
            state         <= ST_IDLE;
            len_q         <= '0;
            word_cnt      <= '0;
            trig_prev     <= 1'b0;
            addr_clear    <= 1'b0;
            rxb0_we       <= 1'b0;
            rxb0_dat      <= '0;
            done          <= 1'b0;
            start_ignored <= 1'b0;
        end else begin
            state      <= state_next;
            trig_prev  <= ext_trig;
            addr_clear <= start_accept;
            rxb0_we    <= pack_valid;
            if (pack_valid) rxb0_dat <= pack_word;
            if (start_accept) begin
                len_q    <= ctl_len;
                word_cnt <= '0;
                done     <= 1'b0;
            end else begin
                if (pack_valid) word_cnt <= word_cnt + CW'(1);
                if (state == ST_DONE) done <= 1'b1;
            end
            if (ctl_start && busy) start_ignored <= 1'b1;
        end
    end

endmodule
